// File: rtl/prio_pkg.sv
// prio_pkg: shared FSM state type and round-robin pointer wrap helper.
package prio_pkg;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic int next_ptr(int idx, int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction
endpackage

// File: rtl/prio_enc_arb_if.sv
// prio_enc_arb_if: request/enable controls and valid/ready result channel.
interface prio_enc_arb_if #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
);
  logic             en;
  logic             rr_mode;
  logic [N-1:0]     req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;
  modport master (output en, rr_mode, req, out_ready, input out_valid, out_idx, out_onehot);
  modport slave  (input en, rr_mode, req, out_ready, output out_valid, out_idx, out_onehot);
endinterface

// File: rtl/prio_find.sv
// prio_find: combinational MSB-first search of a request vector.
module prio_find #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++)
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
  end
endmodule

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered fixed/round-robin priority arbiter with valid/ready output.
module prio_enc_arb
  import prio_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input logic            clk,
  input logic            rst_n,
  prio_enc_arb_if.slave  bus
);
  state_t           state;
  logic [IDX_W-1:0] ptr, ptr_eff, m_idx, u_idx, win;
  logic [N-1:0]     mask;
  logic             m_found, u_found, accept, load;
  assign accept  = (state == FULL) && bus.out_ready;
  // a grant accepted this cycle already rotates the pointer used for the new capture
  assign ptr_eff = accept ? IDX_W'(next_ptr(int'(bus.out_idx), N)) : ptr;
  assign load    = bus.en && u_found && ((state == EMPTY) || bus.out_ready);
  assign win     = (bus.rr_mode && m_found) ? m_idx : u_idx;
  assign bus.out_valid = (state == FULL);
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (i <= int'(ptr_eff));
  end
  prio_find #(.N(N), .IDX_W(IDX_W)) u_masked (
    .req   (bus.req & mask),
    .found (m_found),
    .idx   (m_idx)
  );
  prio_find #(.N(N), .IDX_W(IDX_W)) u_full (
    .req   (bus.req),
    .found (u_found),
    .idx   (u_idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= EMPTY;
      ptr            <= IDX_W'(N - 1);
      bus.out_idx    <= '0;
      bus.out_onehot <= '0;
    end else begin
      ptr <= ptr_eff;
      if (load) begin
        state          <= FULL;
        bus.out_idx    <= win;
        bus.out_onehot <= N'(1) << win;
      end else if (accept) begin
        state          <= EMPTY;
        bus.out_onehot <= '0;
      end
    end
endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: directed + random stimulus checked against a behavioural arbiter model.
module tb_prio_enc_arb;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit mv;
  int mi, mp;
  prio_enc_arb_if #(.N(N)) bus();
  prio_enc_arb #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // first requesting index scanning downward from start, wrapping N-1 after 0
  function automatic int pick(logic [N-1:0] r, int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start - k + N) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mv <= 1'b0;
      mi <= 0;
      mp <= N - 1;
    end else begin : upd
      int p;
      bit ld;
      p  = (mv && bus.out_ready) ? (mi + N - 1) % N : mp;
      ld = bus.en && (bus.req != 0) && (!mv || bus.out_ready);
      mp <= p;
      if (ld) begin
        mv <= 1'b1;
        mi <= pick(bus.req, bus.rr_mode ? p : N - 1);
      end else if (bus.out_ready) mv <= 1'b0;
    end
  always @(negedge clk) begin : cmp
    logic [N-1:0] exp_oh;
    bit ok;
    exp_oh = mv ? (N'(1) << mi) : '0;
    ok = (bus.out_valid == mv) && (bus.out_onehot == exp_oh) && (!mv || int'(bus.out_idx) == mi);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model t=%0t: valid=%0b idx=%0d onehot=%h, required valid=%0b idx=%0d onehot=%h",
               $time, bus.out_valid, bus.out_idx, bus.out_onehot, mv, mi, exp_oh);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, bit v, int idx);
    logic [N-1:0] oh;
    oh = v ? (N'(1) << idx) : '0;
    checks++;
    if (bus.out_valid !== v || bus.out_onehot !== oh || (v && int'(bus.out_idx) != idx)) begin
      errors++;
      $display("FAIL %s: valid=%0b idx=%0d onehot=%h, required valid=%0b idx=%0d onehot=%h",
               nm, bus.out_valid, bus.out_idx, bus.out_onehot, v, idx, oh);
    end
  endtask
  initial begin
    bus.en = 1'b0; bus.rr_mode = 1'b0; bus.req = '0; bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 0, 0);
    bus.en = 1'b1; bus.out_ready = 1'b1; bus.req = 16'h0001;
    step(); chk("fixed_0001", 1, 0);
    bus.req = 16'h8421;
    step(); chk("fixed_8421", 1, 15);
    bus.out_ready = 1'b0; bus.req = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      step(); chk("hold_15", 1, 15);
    end
    bus.out_ready = 1'b1;
    step(); chk("release_hold", 1, 1);
    bus.out_ready = 1'b0; bus.req = 16'h0100;
    step(); chk("held_before_reset", 1, 1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_onehot !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b idx=%0d onehot=%h, required 0 0 0",
               bus.out_valid, bus.out_idx, bus.out_onehot);
    end
    step();
    rst_n = 1'b1; bus.rr_mode = 1'b1; bus.req = 16'hFFFF; bus.out_ready = 1'b1; bus.en = 1'b1;
    step(); chk("rr_first_after_reset", 1, 15);
    for (int i = 14; i >= 0; i--) begin
      step(); chk("rr_full", 1, i);
    end
    step(); chk("rr_full_wrap", 1, 15);
    bus.req = 16'h0081;
    step(); chk("rr_sparse_a", 1, 7);
    step(); chk("rr_sparse_b", 1, 0);
    step(); chk("rr_sparse_c", 1, 7);
    step(); chk("rr_sparse_d", 1, 0);
    bus.req = '0;
    step(); chk("rr_drain", 0, 0);
    bus.en = 1'b0; bus.req = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      step(); chk("en_gated", 0, 0);
    end
    bus.en = 1'b1;
    step(); chk("en_release", 1, 4);
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 4))
        0: bus.req = N'($urandom);
        1: bus.req = N'(1) << $urandom_range(0, N - 1);
        2: bus.req = '0;
        3: bus.req = N'($urandom) & N'($urandom) & N'($urandom);
        default: bus.req = '1;
      endcase
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.rr_mode   = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
